ws2812_write_arbiter: RTL and testbench

//  Shares the single LED-RAM write port of the ws2812 serial driver (write/led_num/rgb_data)

---
 rtl/ws2812_pkg.sv | 24 ++
 rtl/ws2812_write_arbiter_if.sv | 23 ++
 rtl/ws2812_rr_pick.sv | 33 +++
 rtl/ws2812_write_arbiter.sv | 115 +++++++++++
 tb/tb_ws2812_write_arbiter.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ws2812_pkg.sv
// rtl/ws2812_pkg.sv - shared widths, arbiter state encoding and helpers for the ws2812 block
package ws2812_pkg;

  localparam int LED_NUM_W = 8;
  localparam int RGB_W     = 24;

  localparam logic [0:0] ST_ARB  = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  typedef struct packed {
    logic [LED_NUM_W-1:0] led_num;
    logic [RGB_W-1:0]     rgb;
  } pixel_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ws2812_write_arbiter_if.sv
// rtl/ws2812_write_arbiter_if.sv - pixel producer handshake bundle shared by all requesters
interface ws2812_write_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import ws2812_pkg::*;

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_last;
  logic [LED_NUM_W*NUM_REQ-1:0] req_led_num;
  logic [RGB_W*NUM_REQ-1:0]     req_rgb;
  logic [NUM_REQ-1:0]           req_ready;

  modport master (
    output req_valid, req_last, req_led_num, req_rgb,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_last, req_led_num, req_rgb,
    output req_ready
  );

endinterface

// File: rtl/ws2812_rr_pick.sv
// rtl/ws2812_rr_pick.sv - combinational round-robin picker starting the search at rr_ptr
module ws2812_rr_pick
  import ws2812_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  // First requesting index at or after rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    int c;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    c     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      c = int'(rr_ptr) + k;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (!any && req[c]) begin
        any      = 1'b1;
        grant[c] = 1'b1;
        idx      = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/ws2812_write_arbiter.sv
// rtl/ws2812_write_arbiter.sv - round-robin write-port arbiter with burst lock for the ws2812 driver
module ws2812_write_arbiter
  import ws2812_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int NUM_LEDS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  ws2812_write_arbiter_if.slave req,
  output logic                 write,
  output logic [LED_NUM_W-1:0] led_num,
  output logic [RGB_W-1:0]     rgb_data,
  output logic                 err_range,
  output logic [2:0]           err_req_id,
  output logic [15:0]          write_count
);

  localparam int IDX_W = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ);

  logic [0:0]         state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   lock_id;
  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [NUM_REQ-1:0] ready;
  logic [IDX_W-1:0]   sel_id;
  logic [IDX_W-1:0]   next_ptr;
  pixel_t             sel_pix;
  logic               sel_last;
  logic               xfer;
  logic               in_range;

  ws2812_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req    (req.req_valid),
    .rr_ptr (rr_ptr),
    .grant  (pick_grant),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Grant: locked requester only while in LOCK, round-robin pick otherwise; nothing during reset
  always_comb begin
    ready = '0;
    if (!reset) begin
      if (state == ST_LOCK) ready[lock_id] = req.req_valid[lock_id];
      else if (pick_any)    ready = pick_grant;
    end
  end

  assign req.req_ready = ready;
  assign xfer          = |ready;
  assign sel_id        = (state == ST_LOCK) ? lock_id : pick_idx;
  assign sel_pix.led_num = req.req_led_num[int'(sel_id)*LED_NUM_W +: LED_NUM_W];
  assign sel_pix.rgb     = req.req_rgb[int'(sel_id)*RGB_W +: RGB_W];
  assign sel_last      = req.req_last[sel_id];
  assign in_range      = int'(sel_pix.led_num) < NUM_LEDS;
  assign next_ptr      = (int'(sel_id) == NUM_REQ - 1) ? '0 : sel_id + IDX_W'(1);

  // Arbitration state: pointer advances past each winner, last=0 holds the grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_ARB;
      rr_ptr  <= '0;
      lock_id <= '0;
    end else if (xfer) begin
      rr_ptr <= next_ptr;
      if (state == ST_ARB) begin
        if (!sel_last) begin
          state   <= ST_LOCK;
          lock_id <= sel_id;
        end
      end else if (sel_last) begin
        state <= ST_ARB;
      end
    end
  end

  // Output register toward the driver; out-of-range pixels are consumed without a strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write    <= 1'b0;
      led_num  <= '0;
      rgb_data <= '0;
    end else begin
      write <= xfer && in_range;
      if (xfer && in_range) begin
        led_num  <= sel_pix.led_num;
        rgb_data <= sel_pix.rgb;
      end
    end
  end

  // Sticky range error, remembering only the first offender
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_range  <= 1'b0;
      err_req_id <= '0;
    end else if (xfer && !in_range) begin
      err_range <= 1'b1;
      if (!err_range) err_req_id <= 3'(sel_id);
    end
  end

  // Saturating count of strobes issued to the driver
  always_ff @(posedge clk or posedge reset) begin
    if (reset) write_count <= '0;
    else if (write && write_count != 16'hFFFF) write_count <= write_count + 16'd1;
  end

endmodule

// File: tb/tb_ws2812_write_arbiter.sv
// tb/tb_ws2812_write_arbiter.sv - self-checking bench for ws2812_write_arbiter
module tb_ws2812_write_arbiter;
  localparam int N    = 4;
  localparam int LEDS = 8;
  localparam int QD   = 64;

  logic        clk;
  logic        reset;
  logic        write;
  logic [7:0]  led_num;
  logic [23:0] rgb_data;
  logic        err_range;
  logic [2:0]  err_req_id;
  logic [15:0] write_count;

  ws2812_write_arbiter_if #(.NUM_REQ(N)) ifc ();

  ws2812_write_arbiter #(.NUM_REQ(N), .NUM_LEDS(LEDS)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (ifc),
    .write       (write),
    .led_num     (led_num),
    .rgb_data    (rgb_data),
    .err_range   (err_range),
    .err_req_id  (err_req_id),
    .write_count (write_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  // per-requester pixel queues (ring buffers)
  logic [7:0]  qled  [N][QD];
  logic [23:0] qrgb  [N][QD];
  logic        qlast [N][QD];
  int          hd [N];
  int          tl [N];

  // reference model state
  int          m_rr;
  bit          m_lock;
  int          m_lock_id;
  bit          e_write;
  logic [7:0]  e_led;
  logic [23:0] e_rgb;
  bit          e_err;
  int          e_err_id;
  int          e_cnt;
  int          last_g;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rr = 0; m_lock = 0; m_lock_id = 0;
    e_write = 0; e_led = 0; e_rgb = 0; e_err = 0; e_err_id = 0; e_cnt = 0;
  endtask

  task automatic clear_queues();
    for (int r = 0; r < N; r++) begin
      hd[r] = 0;
      tl[r] = 0;
    end
  endtask

  task automatic push(input int r, input int led, input logic [23:0] rgb, input bit last);
    qled[r][tl[r] % QD]  = 8'(led);
    qrgb[r][tl[r] % QD]  = rgb;
    qlast[r][tl[r] % QD] = last;
    tl[r]++;
  endtask

  function automatic int model_grant(input logic [N-1:0] v);
    if (m_lock) return v[m_lock_id] ? m_lock_id : -1;
    for (int k = 0; k < N; k++) begin
      if (v[(m_rr + k) % N]) return (m_rr + k) % N;
    end
    return -1;
  endfunction

  // one clock: drive heads of queues, check grant, step model, check registered outputs
  task automatic cycle();
    int g;
    logic [N-1:0] expr;
    for (int r = 0; r < N; r++) begin
      if (hd[r] != tl[r]) begin
        ifc.req_valid[r]          = 1'b1;
        ifc.req_last[r]           = qlast[r][hd[r] % QD];
        ifc.req_led_num[8*r +: 8] = qled[r][hd[r] % QD];
        ifc.req_rgb[24*r +: 24]   = qrgb[r][hd[r] % QD];
      end else begin
        ifc.req_valid[r]          = 1'b0;
        ifc.req_last[r]           = 1'($urandom_range(0, 1));
        ifc.req_led_num[8*r +: 8] = 8'($urandom);
        ifc.req_rgb[24*r +: 24]   = 24'($urandom);
      end
    end
    #1;
    g = model_grant(ifc.req_valid);
    expr = '0;
    if (g >= 0) expr[g] = 1'b1;
    chk("req_ready", 32'(ifc.req_ready), 32'(expr));
    @(posedge clk);
    last_g = g;
    if (e_write && e_cnt < 65535) e_cnt++;
    e_write = 0;
    if (g >= 0) begin
      if (qled[g][hd[g] % QD] < LEDS) begin
        e_write = 1;
        e_led   = qled[g][hd[g] % QD];
        e_rgb   = qrgb[g][hd[g] % QD];
      end else begin
        if (!e_err) e_err_id = g;
        e_err = 1;
      end
      m_rr = (g + 1) % N;
      if (m_lock) begin
        if (qlast[g][hd[g] % QD]) m_lock = 0;
      end else if (!qlast[g][hd[g] % QD]) begin
        m_lock = 1;
        m_lock_id = g;
      end
      hd[g]++;
    end
    #1;
    chk("write", 32'(write), 32'(e_write));
    chk("led_num", 32'(led_num), 32'(e_led));
    chk("rgb_data", 32'(rgb_data), 32'(e_rgb));
    chk("err_range", 32'(err_range), 32'(e_err));
    chk("err_req_id", 32'(err_req_id), 32'(e_err_id));
    chk("write_count", 32'(write_count), 32'(e_cnt));
    @(negedge clk);
  endtask

  initial begin
    int guard;
    bit busy;
    reset = 1'b1;
    ifc.req_valid = '0;
    ifc.req_last = '0;
    ifc.req_led_num = '0;
    ifc.req_rgb = '0;
    clear_queues();
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_count", 32'(write_count), 32'd0);
    chk("rst_err", 32'(err_range), 32'd0);
    reset = 1'b0;

    // 1: four single-pixel requests, granted 0,1,2,3
    for (int r = 0; r < N; r++) push(r, r, 24'h010203 * 24'(r + 1), 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t1_grant", 32'(last_g), 32'(i));
      chk("t1_led", 32'(led_num), 32'(i));
    end
    cycle();
    chk("t1_count", 32'(write_count), 32'd4);

    // 2: req0 burst 4,5,6 blocks req1 until the last pixel
    push(0, 4, 24'hA00004, 1'b0);
    push(0, 5, 24'hA00005, 1'b0);
    push(0, 6, 24'hA00006, 1'b1);
    push(1, 7, 24'hB00007, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t2_burst_grant", 32'(last_g), 32'd0);
      chk("t2_led", 32'(led_num), 32'(4 + i));
    end
    cycle();
    chk("t2_req1_grant", 32'(last_g), 32'd1);
    chk("t2_req1_led", 32'(led_num), 32'd7);

    // 3: out-of-range pixels consumed, only the first offender recorded
    push(2, 8, 24'hFF0000, 1'b1);
    cycle();
    chk("t3_grant", 32'(last_g), 32'd2);
    chk("t3_nowrite", 32'(write), 32'd0);
    chk("t3_err", 32'(err_range), 32'd1);
    chk("t3_err_id", 32'(err_req_id), 32'd2);
    push(3, 200, 24'h00FF00, 1'b1);
    cycle();
    chk("t3_err_id_keep", 32'(err_req_id), 32'd2);

    // 4: req1 locked with bubbles; others wait; then round-robin resumes at req2
    push(1, 1, 24'h111111, 1'b0);
    cycle();
    push(0, 2, 24'h222222, 1'b1);
    push(2, 3, 24'h333333, 1'b1);
    push(3, 4, 24'h444444, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t4_bubble_nogrant", 32'(last_g), 32'hFFFFFFFF);
    end
    push(1, 5, 24'h555555, 1'b1);
    cycle();
    chk("t4_resume", 32'(last_g), 32'd1);
    cycle();
    chk("t4_rr_next", 32'(last_g), 32'd2);
    repeat (2) cycle();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      for (int r = 0; r < N; r++) begin
        if ($urandom_range(0, 2) == 0 && (tl[r] - hd[r]) < QD - 4)
          push(r, $urandom_range(0, 11), 24'($urandom), $urandom_range(0, 2) != 0);
      end
      cycle();
    end
    // finish any open burst so the queues can drain
    for (int r = 0; r < N; r++) push(r, 0, 24'h0, 1'b1);
    guard = 0;
    busy = 1;
    while (busy && guard < 400) begin
      cycle();
      guard++;
      busy = 0;
      for (int r = 0; r < N; r++) if (hd[r] != tl[r]) busy = 1;
    end
    chk("drain_timeout", 32'(busy), 32'd0);

    // 5: async reset in the middle of a burst, between clock edges
    push(0, 1, 24'hC00001, 1'b0);
    push(0, 2, 24'hC00002, 1'b0);
    push(0, 3, 24'hC00003, 1'b1);
    repeat (2) cycle();
    chk("t5_pre_write", 32'(write), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_write_clr", 32'(write), 32'd0);
    chk("t5_ready_clr", 32'(ifc.req_ready), 32'd0);
    chk("t5_count_clr", 32'(write_count), 32'd0);
    chk("t5_err_clr", 32'(err_range), 32'd0);
    clear_queues();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    push(3, 6, 24'hD00006, 1'b1);
    push(0, 5, 24'hD00005, 1'b1);
    cycle();
    chk("t5_first_grant", 32'(last_g), 32'd0);
    chk("t5_first_led", 32'(led_num), 32'd5);
    cycle();
    chk("t5_second_grant", 32'(last_g), 32'd3);

    // 6: saturate write_count
    guard = 0;
    while (e_cnt < 65535 && guard < 70000) begin
      for (int r = 0; r < N; r++)
        if (hd[r] == tl[r]) push(r, $urandom_range(0, 7), 24'($urandom), 1'b1);
      cycle();
      guard++;
    end
    chk("t6_timeout", 32'(e_cnt), 32'd65535);
    for (int i = 0; i < 3; i++) begin
      for (int r = 0; r < N; r++)
        if (hd[r] == tl[r]) push(r, $urandom_range(0, 7), 24'($urandom), 1'b1);
      cycle();
    end
    chk("t6_saturated", 32'(write_count), 32'h0000FFFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
